// File: rtl/req_encoder_seq.sv
// Sequential N-to-log2(N) request encoder: synchronises request lines, latches events
// into a pending register and issues one index at a time over valid/ready.
// Optional macro ROUND_ROBIN_EN replaces fixed highest-index priority with round-robin.
module req_encoder_seq #(
    parameter int N    = 4,
    parameter int W    = 2,
    parameter bit EDGE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    input  logic         out_ready,
    input  logic         clr_ovf,
    output logic [W-1:0] out_code,
    output logic         out_valid,
    output logic         any_pending,
    output logic         ovf
);

    logic [N-1:0] sync1_q;
    logic [N-1:0] sync2_q;
    logic [N-1:0] reqDly_q;
    logic [N-1:0] pending_q;
    logic [N-1:0] pending_d;
    logic [W-1:0] outCode_q;
    logic         outValid_q;
    logic         ovf_q;
    logic         ovf_d;

    logic [N-1:0] eventVec;
    logic [N-1:0] issueMask;
    logic [W-1:0] selIdx;
    logic         doLoad;
    logic         doIssue;

    assign eventVec = EDGE ? (sync2_q & ~reqDly_q) : sync2_q;
    assign doLoad   = ~outValid_q | out_ready;
    assign doIssue  = doLoad & (|pending_q);

`ifdef ROUND_ROBIN_EN
    logic [W-1:0] lastGrant_q;

    // Search starts just after the last granted index and wraps, so every bit gets a turn.
    always_comb begin
        logic         found;
        logic [W-1:0] idx;
        selIdx = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = lastGrant_q + W'(k);
            if (!found && pending_q[idx]) begin
                selIdx = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrant_q <= W'(N - 1);
        end else if (doIssue) begin
            lastGrant_q <= selIdx;
        end
    end
`else
    // Later iterations overwrite earlier ones, so the highest pending index wins.
    always_comb begin
        selIdx = '0;
        for (int i = 0; i < N; i++) begin
            if (pending_q[i]) begin
                selIdx = W'(i);
            end
        end
    end
`endif

    assign issueMask = doIssue ? (N'(1) << selIdx) : '0;

    // A new event on a bit being issued in the same cycle re-arms it (set wins).
    always_comb begin
        pending_d = (pending_q & ~issueMask) | eventVec;
        ovf_d     = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (EDGE && (|(eventVec & pending_q & ~issueMask))) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            reqDly_q   <= '0;
            pending_q  <= '0;
            outCode_q  <= '0;
            outValid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            sync1_q   <= req_in;
            sync2_q   <= sync1_q;
            reqDly_q  <= sync2_q;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            if (doLoad) begin
                outValid_q <= |pending_q;
                if (|pending_q) begin
                    outCode_q <= selIdx;
                end
            end
        end
    end

    assign out_code    = outCode_q;
    assign out_valid   = outValid_q;
    assign any_pending = |pending_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_req_encoder_seq.sv
// Directed self-checking bench for req_encoder_seq (N=4, EDGE=1); expected codes
// follow ROUND_ROBIN_EN when that macro is defined.
module tb_req_encoder_seq;

    logic       clk;
    logic       rst;
    logic [3:0] req_in;
    logic       out_ready;
    logic       clr_ovf;
    logic [1:0] out_code;
    logic       out_valid;
    logic       any_pending;
    logic       ovf;

    int assertCount;
    int failCount;

    req_encoder_seq #(.N(4), .W(2), .EDGE(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .req_in(req_in),
        .out_ready(out_ready),
        .clr_ovf(clr_ovf),
        .out_code(out_code),
        .out_valid(out_valid),
        .any_pending(any_pending),
        .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic ready, input logic clr);
        req_in    = req;
        out_ready = ready;
        clr_ovf   = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCode(input string tag, input logic [1:0] code);
        checkOutput({tag, " valid"}, {3'b0, out_valid}, 4'h1);
        checkOutput({tag, " code"}, {2'b0, out_code}, {2'b0, code});
    endtask

    logic [1:0] expA, expB, expC;

    initial begin
        assertCount = 0;
        failCount   = 0;
`ifdef ROUND_ROBIN_EN
        expA = 2'd0; expB = 2'd1; expC = 2'd3;
`else
        expA = 2'd3; expB = 2'd1; expC = 2'd0;
`endif
        rst = 1'b1;
        applyStimulus(4'b0000, 1'b1, 1'b0);

        // Reset state
        #2;
        checkOutput("reset valid", {3'b0, out_valid}, 4'h0);
        checkOutput("reset code", {2'b0, out_code}, 4'h0);
        checkOutput("reset any_pending", {3'b0, any_pending}, 4'h0);
        checkOutput("reset ovf", {3'b0, ovf}, 4'h0);
        tick(2);
        rst = 1'b0;
        tick(3);

        // Simultaneous requests
        applyStimulus(4'b1011, 1'b1, 1'b0);
        tick(3);
        checkOutput("simul idle before edge4", {3'b0, out_valid}, 4'h0);
        tick();
        checkCode("simul first", expA);
        checkOutput("simul any_pending mid", {3'b0, any_pending}, 4'h1);
        tick();
        checkCode("simul second", expB);
        tick();
        checkCode("simul third", expC);
        checkOutput("simul any_pending cleared", {3'b0, any_pending}, 4'h0);
        tick();
        checkOutput("simul done valid", {3'b0, out_valid}, 4'h0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick(4);

        // Single request latency
        applyStimulus(4'b0100, 1'b1, 1'b0);
        tick(3);
        checkOutput("single edge3 valid", {3'b0, out_valid}, 4'h0);
        tick();
        checkCode("single edge4", 2'd2);
        checkOutput("single any_pending", {3'b0, any_pending}, 4'h0);
        tick();
        checkOutput("single one cycle", {3'b0, out_valid}, 4'h0);
        checkOutput("single code holds", {2'b0, out_code}, 4'h2);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick(4);

        // Backpressure
        applyStimulus(4'b0001, 1'b0, 1'b0);
        tick();
        applyStimulus(4'b0100, 1'b0, 1'b0);
        tick(3);
        checkCode("bp loaded", 2'd0);
        checkOutput("bp any_pending", {3'b0, any_pending}, 4'h1);
        tick(10);
        checkCode("bp held", 2'd0);
        checkOutput("bp any_pending held", {3'b0, any_pending}, 4'h1);
        applyStimulus(4'b0100, 1'b1, 1'b0);
        tick();
        checkCode("bp second", 2'd2);
        checkOutput("bp drained", {3'b0, any_pending}, 4'h0);
        tick();
        checkOutput("bp done valid", {3'b0, out_valid}, 4'h0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick(4);

        // Overflow: park code 3 in the output, then pulse bit 1 twice
        applyStimulus(4'b1000, 1'b0, 1'b0);
        tick(4);
        checkCode("ovf busy", 2'd3);
        applyStimulus(4'b1010, 1'b0, 1'b0);
        tick(3);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        tick(3);
        applyStimulus(4'b1010, 1'b0, 1'b0);
        tick(2);
        checkOutput("ovf before second edge", {3'b0, ovf}, 4'h0);
        checkOutput("ovf pending bit1", {3'b0, any_pending}, 4'h1);
        tick();
        checkOutput("ovf set", {3'b0, ovf}, 4'h1);
        tick(2);
        checkOutput("ovf sticky", {3'b0, ovf}, 4'h1);
        applyStimulus(4'b1010, 1'b0, 1'b1);
        tick();
        applyStimulus(4'b1010, 1'b0, 1'b0);
        checkOutput("ovf cleared", {3'b0, ovf}, 4'h0);
        checkCode("ovf still busy", 2'd3);
        applyStimulus(4'b1010, 1'b1, 1'b0);
        tick();
        checkCode("ovf single code1", 2'd1);
        tick();
        checkOutput("ovf no second code1", {3'b0, out_valid}, 4'h0);
        tick();
        checkOutput("ovf still idle", {3'b0, out_valid}, 4'h0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick(4);

        // Set/clear collision on bit 2
        applyStimulus(4'b1000, 1'b0, 1'b0);
        tick(4);
        applyStimulus(4'b1100, 1'b0, 1'b0);
        tick(3);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        tick(3);
        applyStimulus(4'b1100, 1'b0, 1'b0);
        tick(2);
        applyStimulus(4'b1100, 1'b1, 1'b0);
        tick();
        checkCode("collision issue", 2'd2);
        checkOutput("collision pending kept", {3'b0, any_pending}, 4'h1);
        checkOutput("collision no ovf", {3'b0, ovf}, 4'h0);
        tick();
        checkCode("collision reissue", 2'd2);
        checkOutput("collision drained", {3'b0, any_pending}, 4'h0);
        tick();
        checkOutput("collision done valid", {3'b0, out_valid}, 4'h0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick(4);

        // Reset mid-operation
        applyStimulus(4'b0001, 1'b0, 1'b0);
        tick(4);
        checkCode("midrst busy", 2'd0);
        applyStimulus(4'b1011, 1'b0, 1'b0);
        tick(3);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("midrst pending", {3'b0, any_pending}, 4'h1);
        tick();
        rst = 1'b1;
        #1;
        checkOutput("midrst valid", {3'b0, out_valid}, 4'h0);
        checkOutput("midrst code", {2'b0, out_code}, 4'h0);
        checkOutput("midrst any_pending", {3'b0, any_pending}, 4'h0);
        tick(2);
        rst = 1'b0;
        applyStimulus(4'b1000, 1'b1, 1'b0);
        tick(3);
        checkOutput("midrst edge3 valid", {3'b0, out_valid}, 4'h0);
        tick();
        checkCode("midrst redetect", 2'd3);
        tick();
        checkOutput("midrst only code3", {3'b0, out_valid}, 4'h0);
        tick(2);
        checkOutput("midrst idle", {3'b0, out_valid}, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/req_encoder_seq.md
Name: req_encoder_seq

Overview:
- Sequential N-to-log2(N) request encoder, the inverse of the 2-to-4 line decoder.
- Captures events on N asynchronous request lines into a pending register.
- Issues one binary-coded index at a time over a valid/ready handshake.
- Sits between external request sources (switches, interrupt lines) and the consumer that re-decodes the code.

Parameters:
- N, 4, number of request lines (power of 2, 2..16).
- W, 2, code width; must equal log2(N).
- EDGE, 1, 1 = capture on rising edge of a synchronised request; 0 = level capture.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_in  input  N  asynchronous request lines.
- out_ready  input  1  consumer accepts the current code.
- clr_ovf  input  1  synchronous clear of ovf.
- out_code  output  W  encoded index of the issued request.
- out_valid  output  1  out_code holds a valid index.
- any_pending  output  1  OR of the pending register.
- ovf  output  1  sticky flag: an event was lost.

Behaviour:
- Reset:
  - Asserting rst immediately clears sync1, sync2, req_d, pending, out_code, out_valid and ovf to 0.
  - Mid-operation reset discards all pending and in-flight codes.
  - After release, a req_in held high is re-detected as a new rising edge, because req_d restarts at 0.
- Synchroniser: two flops, sync1 then sync2 (req_s). req_d holds the previous req_s.
- Event per bit i:
  - EDGE=1: req_s[i] & ~req_d[i].
  - EDGE=0: req_s[i].
- Pending update each cycle: pending_next = (pending & ~issue_mask) | event.
  - issue_mask is one-hot for the bit loaded this cycle, else 0.
  - A set and a clear of the same bit in the same cycle leaves the bit at 1 (set wins).
- Overflow:
  - EDGE=1 only: an event on a bit already pending and not cleared this cycle sets ovf.
  - clr_ovf clears ovf. If both occur in the same cycle, set wins.
- Output stage loads when (~out_valid | out_ready):
  - pending != 0: out_code <= selected index, out_valid <= 1, set issue_mask.
  - pending == 0: out_valid <= 0, out_code holds its last value.
- Selection: fixed priority, highest index wins (for N=4: bit3 > bit2 > bit1 > bit0).
- Hold rule: while out_valid & ~out_ready, out_code and out_valid are stable and pending keeps accumulating.
- Throughput: one code per cycle when out_ready is held high and pending bits remain.
- Latency (EDGE=1, out_ready=1, idle), counted from req_in high before clock edge 1:
  - sync1 at edge 1, sync2 at edge 2, pending at edge 3.
  - out_valid=1 with code after edge 4.
- Timing of any_pending: combinational from the pending register. It clears in the same cycle the last bit issues.
- Handshake completes on a clock edge where out_valid & out_ready.

Optional Feature:
- Macro: ROUND_ROBIN_EN.
- Defined:
  - A W-bit last-grant register, reset value N-1, updated with each issued index.
  - Search order is last+1, last+2, ..., last (mod N); first pending bit wins.
  - Guarantees no starvation: with all bits pending, N=4 issues 0,1,2,3,0,...
- Not defined:
  - Fixed highest-index priority as above.
  - No last-grant register is instantiated.

Test Plan:
- Reset and single request:
  - Stimulus: rst pulse, then req_in=4'b0100 with out_ready=1.
  - Response: all outputs 0 during reset; out_valid=1, out_code=2 exactly 4 edges after req_in rises, for one cycle; any_pending returns to 0.
- Simultaneous requests, fixed priority:
  - Stimulus: req_in 0000->1011 in one cycle, out_ready=1.
  - Response: codes 3,1,0 on consecutive cycles, then out_valid=0.
  - With ROUND_ROBIN_EN: codes 0,1,3.
- Backpressure:
  - Stimulus: req_in=0001 then 0100 while out_ready=0 for 10 cycles.
  - Response: out_valid held with out_code=0 stable, any_pending=1.
  - After out_ready=1: code 0 accepted, then code 2.
- Overflow:
  - Stimulus: out_ready=0; pulse req_in[1] high-low-high (each phase 3 cycles).
  - Response: ovf=1 after the second edge reaches pending; clr_ovf for 1 cycle gives ovf=0; only one code 1 is issued.
- Set/clear collision:
  - Stimulus: a bit-2 event coincides with the cycle code 2 issues.
  - Response: pending[2] stays 1 and code 2 is issued again next load.
- Reset mid-operation:
  - Stimulus: assert rst while out_valid=1 and pending=1010, with req_in=1000 held.
  - Response: outputs 0 immediately; after release, only code 3 is issued, 4 edges later.
